// File: rtl/jogo_memoria_param.sv
// rtl/jogo_memoria_param.sv - parametrised sequence-memory game controller with external ROM port
module jogo_memoria_param #(
   parameter int N_BOTOES       = 4,
   parameter int PROFUNDIDADE   = 16,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int CICLOS_LED     = 1000,
   localparam int AW            = $clog2(PROFUNDIDADE)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                modo,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [AW-1:0]       mem_endereco,
   input  logic [N_BOTOES-1:0] mem_dado,
   output logic [N_BOTOES-1:0] leds,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic                db_timeout,
   output logic [AW-1:0]       db_rodada,
   output logic [3:0]          db_estado
);

   localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam int LW = (CICLOS_LED > 1) ? $clog2(CICLOS_LED) : 1;
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CICLOS - 1);
   localparam logic [LW-1:0] LED_MAX     = LW'(CICLOS_LED - 1);
   localparam logic [AW-1:0] RODADA_MAX  = AW'(PROFUNDIDADE - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARACAO     = 4'd1,
      MOSTRA         = 4'd2,
      ESPERA_JOGADA  = 4'd3,
      REGISTRA       = 4'd4,
      COMPARA        = 4'd5,
      PROXIMA_JOGADA = 4'd6,
      PROXIMA_RODADA = 4'd7,
      FIM_GANHOU     = 4'd8,
      FIM_PERDEU     = 4'd9,
      FIM_TIMEOUT    = 4'd10
   } estado_t;

   estado_t             estado;
   logic [AW-1:0]       rodada;
   logic [AW-1:0]       endereco;
   logic                modo_r;
   logic [N_BOTOES-1:0] jogada;
   logic [TW-1:0]       cnt_timeout;
   logic [LW-1:0]       cnt_led;
   logic                botao_ant;
   logic                jogada_nova;

   // A play is the rising edge of "any button pressed"; a held button never re-triggers
   assign jogada_nova  = (|botoes) & ~botao_ant;

   assign mem_endereco = endereco;
   assign db_rodada    = rodada;
   assign db_estado    = estado;

   // Previous-cycle copy of the OR of all buttons, tracked in every state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         botao_ant <= 1'b0;
      end else begin
         botao_ant <= |botoes;
      end
   end

   // LEDs follow the ROM while showing an item (ROM data is combinational with the address)
   always_comb begin
      leds = '0;
      if (estado == MOSTRA) begin
         leds = mem_dado;
      end else if (estado == ESPERA_JOGADA) begin
         leds = botoes;
      end
   end

   // Game FSM: state, counters, address and result flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado      <= INICIAL;
         rodada      <= '0;
         endereco    <= '0;
         modo_r      <= 1'b0;
         jogada      <= '0;
         cnt_timeout <= '0;
         cnt_led     <= '0;
         pronto      <= 1'b0;
         ganhou      <= 1'b0;
         perdeu      <= 1'b0;
         db_timeout  <= 1'b0;
      end else begin
         // Both timers restart whenever their state is (re)entered
         if (estado != ESPERA_JOGADA) cnt_timeout <= '0;
         if (estado != MOSTRA)        cnt_led     <= '0;

         case (estado)
            INICIAL: begin
               if (iniciar) begin
                  estado   <= PREPARACAO;
                  rodada   <= '0;
                  endereco <= '0;
               end
            end

            PREPARACAO: begin
               rodada   <= '0;
               endereco <= '0;
               modo_r   <= modo;
               estado   <= modo ? ESPERA_JOGADA : MOSTRA;
            end

            MOSTRA: begin
               if (cnt_led == LED_MAX) begin
                  endereco <= '0;
                  estado   <= ESPERA_JOGADA;
               end else begin
                  cnt_led <= cnt_led + 1'b1;
               end
            end

            ESPERA_JOGADA: begin
               // A press on the limit edge wins over the timeout
               if (jogada_nova) begin
                  estado <= REGISTRA;
               end else if (cnt_timeout == TIMEOUT_MAX) begin
                  estado     <= FIM_TIMEOUT;
                  pronto     <= 1'b1;
                  perdeu     <= 1'b1;
                  db_timeout <= 1'b1;
               end else begin
                  cnt_timeout <= cnt_timeout + 1'b1;
               end
            end

            REGISTRA: begin
               jogada <= botoes;
               estado <= COMPARA;
            end

            COMPARA: begin
               if (jogada != mem_dado) begin
                  estado <= FIM_PERDEU;
                  pronto <= 1'b1;
                  perdeu <= 1'b1;
               end else if (endereco != rodada) begin
                  estado <= PROXIMA_JOGADA;
               end else if (rodada == RODADA_MAX) begin
                  estado <= FIM_GANHOU;
                  pronto <= 1'b1;
                  ganhou <= 1'b1;
               end else begin
                  estado <= PROXIMA_RODADA;
               end
            end

            PROXIMA_JOGADA: begin
               endereco <= endereco + 1'b1;
               estado   <= ESPERA_JOGADA;
            end

            PROXIMA_RODADA: begin
               // In display mode the address points at the new item right away
               rodada   <= rodada + 1'b1;
               endereco <= modo_r ? '0 : rodada + 1'b1;
               estado   <= modo_r ? ESPERA_JOGADA : MOSTRA;
            end

            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
               if (iniciar) begin
                  estado     <= PREPARACAO;
                  rodada     <= '0;
                  endereco   <= '0;
                  pronto     <= 1'b0;
                  ganhou     <= 1'b0;
                  perdeu     <= 1'b0;
                  db_timeout <= 1'b0;
               end
            end

            default: begin
               estado <= INICIAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb/tb_jogo_memoria_param.sv - self-checking bench for jogo_memoria_param
module tb_jogo_memoria_param;

   localparam int NB = 4;
   localparam int D  = 4;
   localparam int TO = 20;
   localparam int CL = 3;
   localparam int AW = 2;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          iniciar = 1'b0;
   logic          modo    = 1'b0;
   logic [NB-1:0] botoes  = '0;
   logic [AW-1:0] mem_endereco;
   logic [NB-1:0] mem_dado;
   logic [NB-1:0] leds;
   logic          pronto, ganhou, perdeu, db_timeout;
   logic [AW-1:0] db_rodada;
   logic [3:0]    db_estado;

   logic [NB-1:0] rom [0:D-1];
   int n_assert = 0;
   int n_fail   = 0;

   assign mem_dado = rom[mem_endereco];

   always #5 clock = ~clock;

   jogo_memoria_param #(
      .N_BOTOES(NB), .PROFUNDIDADE(D), .TIMEOUT_CICLOS(TO), .CICLOS_LED(CL)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .botoes(botoes),
      .mem_endereco(mem_endereco), .mem_dado(mem_dado), .leds(leds),
      .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
      .db_rodada(db_rodada), .db_estado(db_estado)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_st(input string tag, input int e);
      chk(tag, 32'(db_estado), e);
   endtask

   task automatic chk_flags(input string tag, input logic p, input logic g, input logic l, input logic t);
      chk({tag, ".pronto"}, 32'(pronto), 32'(p));
      chk({tag, ".ganhou"}, 32'(ganhou), 32'(g));
      chk({tag, ".perdeu"}, 32'(perdeu), 32'(l));
      chk({tag, ".timeout"}, 32'(db_timeout), 32'(t));
   endtask

   task automatic set_fixed_rom();
      for (int k = 0; k < D; k++) rom[k] = NB'(1 << k);
   endtask

   task automatic do_reset(input string tag);
      botoes  = '0;
      iniciar = 1'b0;
      reset   = 1'b1;
      #1;
      chk_st({tag, ".estado"}, 0);
      chk({tag, ".leds"}, 32'(leds), 0);
      chk({tag, ".endereco"}, 32'(mem_endereco), 0);
      chk({tag, ".rodada"}, 32'(db_rodada), 0);
      chk_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic start_game(input logic m);
      iniciar = 1'b1;
      modo    = m;
      tick();
      chk_st("start.prep", 1);
      chk_flags("start", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("start.rodada", 32'(db_rodada), 0);
      iniciar = 1'b0;
      tick();
      chk_st("start.next", m ? 3 : 2);
   endtask

   // Present a play from espera_jogada and check the state reached after the comparison
   task automatic press_check(input logic [NB-1:0] v, input int exp_state);
      botoes = v;
      #1;
      chk("espera.leds_echo", 32'(leds), 32'(v));
      tick();
      chk_st("registra", 4);
      tick();
      chk_st("compara", 5);
      botoes = '0;
      tick();
      chk_st("after_compara", exp_state);
   endtask

   task automatic check_mostra(input logic [NB-1:0] item, input int r);
      for (int c = 0; c < CL; c++) begin
         chk_st("mostra.estado", 2);
         chk("mostra.leds", 32'(leds), 32'(item));
         chk("mostra.endereco", 32'(mem_endereco), r);
         tick();
      end
      chk_st("mostra.end", 3);
      chk("mostra.leds_off", 32'(leds), 0);
   endtask

   // Plays a whole game; the outcome of each play comes from the game rules
   // (first mismatch loses, last item of the last round wins)
   task automatic run_game(input logic m, input int err_r, input int err_i, input logic [NB-1:0] wrong);
      logic [NB-1:0] v;
      int  e;
      bit  done;
      done = 0;
      start_game(m);
      if (!m) check_mostra(rom[0], 0);
      for (int r = 0; r < D && !done; r++) begin
         for (int i = 0; i <= r && !done; i++) begin
            v = rom[i];
            if (r == err_r && i == err_i) begin
               v = wrong;
               while (v == '0 || v == rom[i]) v = NB'($urandom_range(1, (1 << NB) - 1));
            end
            if (v != rom[i])     e = 9;
            else if (i < r)      e = 6;
            else if (r == D - 1) e = 8;
            else                 e = 7;
            press_check(v, e);
            chk("game.rodada", 32'(db_rodada), r);
            if (e == 9) begin
               chk_flags("game.lost", 1'b1, 1'b0, 1'b1, 1'b0);
               done = 1;
            end else if (e == 8) begin
               chk_flags("game.won", 1'b1, 1'b1, 1'b0, 1'b0);
               done = 1;
            end else if (e == 6) begin
               tick();
               chk_st("game.wait_next", 3);
            end else begin
               tick();
               if (!m) check_mostra(rom[r + 1], r + 1);
               else    chk_st("game.wait_round", 3);
               chk("game.new_rodada", 32'(db_rodada), r + 1);
            end
         end
      end
   endtask

   initial begin
      int er, ei;
      logic mm;
      set_fixed_rom();

      // Reset state
      do_reset("reset");

      // Win in blind mode
      run_game(1'b1, -1, -1, '0);
      chk("win.rodada", 32'(db_rodada), 3);
      chk_st("win.estado", 8);

      // Loss in round 2: 0001 then 0100
      run_game(1'b1, 1, 1, 4'b0100);
      chk_st("loss.estado", 9);

      // Restart from fim_perdeu, then timeout after 20 idle cycles
      start_game(1'b1);
      for (int j = 1; j < TO; j++) begin
         tick();
         chk_st("timeout.waiting", 3);
      end
      tick();
      chk_st("timeout.estado", 10);
      chk_flags("timeout", 1'b1, 1'b0, 1'b1, 1'b1);

      // Press on the limit edge counts as a play
      start_game(1'b1);
      for (int j = 1; j < TO; j++) tick();
      chk_st("limit.waiting", 3);
      press_check(rom[0], 7);
      tick();
      chk_st("limit.next_round", 3);

      // Display mode, full win with item display each round
      do_reset("reset2");
      run_game(1'b0, -1, -1, '0);
      chk_st("display_win.estado", 8);

      // Press during mostra is ignored
      start_game(1'b0);
      botoes = rom[0];
      tick();
      chk_st("mostra_press.a", 2);
      botoes = '0;
      tick();
      chk_st("mostra_press.b", 2);
      tick();
      chk_st("mostra_press.espera", 3);
      tick();
      tick();
      chk_st("mostra_press.ignored", 3);

      // Multi-button press is always wrong
      do_reset("reset3");
      start_game(1'b1);
      press_check(4'b0011, 9);
      chk_flags("multi", 1'b1, 1'b0, 1'b1, 1'b0);

      // Button held across the round boundary registers once
      start_game(1'b1);
      botoes = rom[0];
      tick();
      chk_st("held.registra", 4);
      tick();
      chk_st("held.compara", 5);
      tick();
      chk_st("held.proxima_rodada", 7);
      tick();
      chk_st("held.espera", 3);
      chk("held.rodada", 32'(db_rodada), 1);
      tick();
      tick();
      chk_st("held.no_second_play", 3);
      botoes = '0;
      tick();
      chk_st("held.released", 3);
      press_check(rom[0], 6);
      tick();
      press_check(rom[1], 7);

      // Asynchronous reset in the middle of round 3's display
      do_reset("reset4");
      start_game(1'b0);
      check_mostra(rom[0], 0);
      press_check(rom[0], 7);
      tick();
      check_mostra(rom[1], 1);
      press_check(rom[0], 6);
      tick();
      press_check(rom[1], 7);
      tick();
      chk_st("mid.mostra", 2);
      chk("mid.rodada", 32'(db_rodada), 2);
      chk("mid.leds", 32'(leds), 32'(rom[2]));
      do_reset("mid_reset");

      // Randomized games against the rule model
      for (int g = 0; g < 8; g++) begin
         for (int k = 0; k < D; k++) rom[k] = NB'(1 << $urandom_range(0, NB - 1));
         mm = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) begin
            er = -1;
            ei = -1;
         end else begin
            er = int'($urandom_range(0, D - 1));
            ei = int'($urandom_range(0, er));
         end
         run_game(mm, er, ei, NB'($urandom_range(0, (1 << NB) - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
